apb3_cam_multi_ctrl: RTL and testbench
======================================

APB3_CAM_MULTI_CTRL -- requirements
Module: apb3_cam_multi_ctrl

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL take parameter NUM_CAM, default 2, legal range 1..4, camera channel count.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have APB3 slave ports: PADDR in ADDR_WIDTH; PSEL, PENABLE and PWRITE in 1; PWDATA in 32; PRDATA out 32; PREADY out 1; PSLVERROR out 1.
REQ-006 SHALL have mipi_rst out 1, and irq out 1 (level interrupt).
REQ-007 SHALL have per-camera flattened outputs, slice c = camera c: cam_rgb_control out 16*NUM_CAM; cam_trigger_capture, cam_continuous_capture, cam_rgb_gray and cam_dma_init_done out NUM_CAM each.
REQ-008 SHALL have per-camera flattened inputs: cam_frames_per_second, cam_dma_fifo_rcount, cam_dma_fifo_wcount and cam_dma_status in 32*NUM_CAM each; cam_frame_done in NUM_CAM (1-cycle pulses).
REQ-009 SHALL have global inputs debug_fifo_status, debug_display_dma_fifo_rcount and debug_display_dma_fifo_wcount, in 32 each.

Function
REQ-010 SHALL decode the global register map at byte offsets: 0x00 CTRL RW (bit0 mipi_rst, bits[NUM_CAM+7:8] irq_en); 0x04 ID RO = 0xABCD_5600 | NUM_CAM; 0x08 IRQ_STATUS W1C (bits[NUM_CAM-1:0]); 0x0C/0x10/0x14 RO debug_fifo_status, display rcount, display wcount.
REQ-011 SHALL decode the per-camera block for camera c at 0x100 + 0x40*c: +0x00 RGB_CTRL RW [15:0]; +0x04 CAP RW (bit0 trigger, bit1 continuous); +0x08 MODE RW (bit0 rgb_gray, bit1 dma_init_done); +0x0C/+0x10/+0x14/+0x18 RO fps, rcount, wcount, dma_status; +0x1C FRAME_CNT.
REQ-012 SHALL decode on PADDR[ADDR_WIDTH-1:2]; PADDR[1:0] SHALL be ignored.
REQ-013 SHALL run an APB FSM IDLE -> SETUP (PSEL & !PENABLE) -> ACCESS (PSEL & PENABLE) -> WAIT -> IDLE; SETUP with !(PSEL & PENABLE) returns to IDLE.
REQ-014 SHALL assert PREADY for exactly one cycle, in WAIT, giving a fixed single wait state; PREADY SHALL be 0 in all other states.
REQ-015 SHALL register PRDATA in ACCESS and hold it until the next read; unmapped reads return 0.
REQ-016 SHALL assert PSLVERROR together with PREADY for an unmapped address, a camera index >= NUM_CAM, or a write to an RO register; an errored write SHALL modify no state.
REQ-017 SHALL commit writes in the ACCESS cycle; unused bits SHALL read 0.
REQ-018 SHALL make CAP bit0 self-clearing: a write of 1 drives cam_trigger_capture[c] high for exactly one clk cycle, and CAP bit0 SHALL read 0.
REQ-019 SHALL set IRQ_STATUS[c] on cam_frame_done[c]; writing 1 clears the bit; on a same-cycle set and clear, the set SHALL win.
REQ-020 SHALL drive irq = |(IRQ_STATUS & irq_en), registered, one cycle after a status change.
REQ-021 SHALL make FRAME_CNT a 32-bit counter incremented by cam_frame_done[c], wrapping 0xFFFF_FFFF -> 0; any write clears it to 0; a write in the same cycle as an increment yields 1.
REQ-022 SHALL capture RO inputs at the read sample point (ACCESS cycle), with no extra synchronisation.

Reset
REQ-023 SHALL, on resetn low, immediately clear all RW registers, IRQ_STATUS, FRAME_CNT, PRDATA, irq and trigger pulses, force FSM to IDLE, and hold all outputs at 0.
REQ-024 SHALL, when reset occurs mid-transfer, abandon the transfer with no write committed; after release the FSM SHALL require a fresh SETUP.

Verification
REQ-025 SHALL verify: write 0x0000_1234 to 0x100, then read 0x100 -> cam_rgb_control[15:0]=0x1234; PRDATA=0x0000_1234; PREADY 2 cycles after SETUP.
REQ-026 SHALL verify: read 0x04 with NUM_CAM=2 -> 0xABCD_5602; read 0x1C0 -> PSLVERROR=1, PRDATA=0.
REQ-027 SHALL verify: write 0x3 to 0x144 -> cam_trigger_capture[1] high for 1 cycle; cam_continuous_capture[1]=1; readback=0x2.
REQ-028 SHALL verify: irq_en=0x1 (CTRL=0x100), pulse cam_frame_done[0] -> IRQ_STATUS=0x1, irq=1; W1C 0x1 in the same cycle as a new pulse -> status stays 1.
REQ-029 SHALL verify: 3 frame_done pulses -> FRAME_CNT=3; write to 0x10C (RO) -> PSLVERROR=1, no change.
REQ-030 SHALL verify: assert resetn low during ACCESS of a write 0x1 to 0x00 -> mipi_rst=0, PREADY=0, FSM IDLE.

Source files
------------

// File: rtl/apb3_cam_multi_ctrl.sv
// APB3 register slave controlling up to four camera channels: global control,
// level interrupt with W1C status, per-camera control/status and frame counters.
module apb3_cam_multi_ctrl #(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_CAM    = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [ADDR_WIDTH-1:0]  PADDR,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [31:0]            PWDATA,
   output logic [31:0]            PRDATA,
   output logic                   PREADY,
   output logic                   PSLVERROR,
   output logic                   mipi_rst,
   output logic                   irq,
   output logic [16*NUM_CAM-1:0]  cam_rgb_control,
   output logic [NUM_CAM-1:0]     cam_trigger_capture,
   output logic [NUM_CAM-1:0]     cam_continuous_capture,
   output logic [NUM_CAM-1:0]     cam_rgb_gray,
   output logic [NUM_CAM-1:0]     cam_dma_init_done,
   input  logic [32*NUM_CAM-1:0]  cam_frames_per_second,
   input  logic [32*NUM_CAM-1:0]  cam_dma_fifo_rcount,
   input  logic [32*NUM_CAM-1:0]  cam_dma_fifo_wcount,
   input  logic [32*NUM_CAM-1:0]  cam_dma_status,
   input  logic [NUM_CAM-1:0]     cam_frame_done,
   input  logic [31:0]            debug_fifo_status,
   input  logic [31:0]            debug_display_dma_fifo_rcount,
   input  logic [31:0]            debug_display_dma_fifo_wcount
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT} state_t;

   state_t               state_q, state_d;
   logic [31:0]          prdata_q;
   logic                 err_q;
   logic                 mipi_q;
   logic [NUM_CAM-1:0]   irqen_q;
   logic [NUM_CAM-1:0]   irqst_q, irqst_d;
   logic                 irq_q;
   logic [NUM_CAM-1:0]   trig_q, trig_d;
   logic [NUM_CAM-1:0]   cont_q, gray_q, dinit_q;
   logic [15:0]          rgb_q  [NUM_CAM];
   logic [31:0]          fcnt_q [NUM_CAM];

   logic [29:0]          wa;
   logic [2:0]           reg_idx;
   logic                 glb;
   logic                 dec_ok, dec_ro;
   logic [31:0]          rdata;
   logic [NUM_CAM-1:0]   cam_sel;
   logic                 access_w, wr_en;
   logic                 unused_bits;

   // Word address: the byte-lane bits of PADDR take no part in decoding.
   assign wa          = 30'(PADDR[ADDR_WIDTH-1:2]);
   assign reg_idx     = wa[2:0];
   assign glb         = (wa[29:3] == 27'd0);
   assign access_w    = (state_q == S_ACCESS);
   assign wr_en       = access_w && PWRITE && dec_ok && !dec_ro;
   assign unused_bits = ^{PADDR[1:0], PWDATA};

   // APB handshake sequencing; a fresh SETUP phase is required to leave IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (PSEL && !PENABLE) state_d = S_SETUP;
         S_SETUP:  state_d = (PSEL && PENABLE) ? S_ACCESS : S_IDLE;
         S_ACCESS: state_d = S_WAIT;
         S_WAIT:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Address decode, access-type classification and read data mux.
   always_comb begin
      dec_ok  = 1'b0;
      dec_ro  = 1'b0;
      rdata   = '0;
      cam_sel = '0;
      if (glb) begin
         dec_ok = 1'b1;
         case (reg_idx)
            3'd0: rdata = 32'(mipi_q) | (32'(irqen_q) << 8);
            3'd1: begin rdata = 32'hABCD_5600 | 32'(NUM_CAM); dec_ro = 1'b1; end
            3'd2: rdata = 32'(irqst_q);
            3'd3: begin rdata = debug_fifo_status;             dec_ro = 1'b1; end
            3'd4: begin rdata = debug_display_dma_fifo_rcount; dec_ro = 1'b1; end
            3'd5: begin rdata = debug_display_dma_fifo_wcount; dec_ro = 1'b1; end
            default: dec_ok = 1'b0;
         endcase
      end else if ((wa[29:6] == 24'd1) && !wa[3]) begin
         for (int c = 0; c < NUM_CAM; c++) begin
            if (wa[5:4] == 2'(c)) begin
               dec_ok     = 1'b1;
               cam_sel[c] = 1'b1;
               case (reg_idx)
                  3'd0: rdata = 32'(rgb_q[c]);
                  3'd1: rdata = {30'd0, cont_q[c], 1'b0};
                  3'd2: rdata = {30'd0, dinit_q[c], gray_q[c]};
                  3'd3: begin rdata = cam_frames_per_second[32*c +: 32]; dec_ro = 1'b1; end
                  3'd4: begin rdata = cam_dma_fifo_rcount[32*c +: 32];   dec_ro = 1'b1; end
                  3'd5: begin rdata = cam_dma_fifo_wcount[32*c +: 32];   dec_ro = 1'b1; end
                  3'd6: begin rdata = cam_dma_status[32*c +: 32];        dec_ro = 1'b1; end
                  default: rdata = fcnt_q[c];
               endcase
            end
         end
      end
      if (!dec_ok) rdata = '0;
   end

   // Next interrupt status (frame_done set beats W1C clear) and trigger pulses.
   always_comb begin
      irqst_d = irqst_q;
      if (wr_en && glb && (reg_idx == 3'd2)) irqst_d = irqst_q & ~PWDATA[NUM_CAM-1:0];
      irqst_d = irqst_d | cam_frame_done;
      trig_d  = '0;
      for (int c = 0; c < NUM_CAM; c++) begin
         if (wr_en && cam_sel[c] && (reg_idx == 3'd1)) trig_d[c] = PWDATA[0];
      end
   end

   // FSM state, read data capture and error flag for the response phase.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         prdata_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (access_w) begin
            err_q <= !dec_ok || (PWRITE && dec_ro);
            if (!PWRITE) prdata_q <= rdata;
         end
      end
   end

   // Global control, interrupt status/line and one-cycle trigger pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mipi_q  <= 1'b0;
         irqen_q <= '0;
         irqst_q <= '0;
         irq_q   <= 1'b0;
         trig_q  <= '0;
      end else begin
         if (wr_en && glb && (reg_idx == 3'd0)) begin
            mipi_q  <= PWDATA[0];
            irqen_q <= PWDATA[NUM_CAM+7:8];
         end
         irqst_q <= irqst_d;
         irq_q   <= |(irqst_q & irqen_q);
         trig_q  <= trig_d;
      end
   end

   // Per-camera control registers and wrapping frame counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cont_q  <= '0;
         gray_q  <= '0;
         dinit_q <= '0;
         for (int c = 0; c < NUM_CAM; c++) begin
            rgb_q[c]  <= '0;
            fcnt_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CAM; c++) begin
            if (wr_en && cam_sel[c]) begin
               case (reg_idx)
                  3'd0: rgb_q[c] <= PWDATA[15:0];
                  3'd1: cont_q[c] <= PWDATA[1];
                  3'd2: begin gray_q[c] <= PWDATA[0]; dinit_q[c] <= PWDATA[1]; end
                  default: ;
               endcase
            end
            if (wr_en && cam_sel[c] && (reg_idx == 3'd7)) fcnt_q[c] <= 32'(cam_frame_done[c]);
            else if (cam_frame_done[c])                   fcnt_q[c] <= fcnt_q[c] + 32'd1;
         end
      end
   end

   // Flatten per-camera RGB control words onto the output bus.
   always_comb begin
      cam_rgb_control = '0;
      for (int c = 0; c < NUM_CAM; c++) cam_rgb_control[16*c +: 16] = rgb_q[c];
   end

   assign PRDATA                 = prdata_q;
   assign PREADY                 = (state_q == S_WAIT);
   assign PSLVERROR              = (state_q == S_WAIT) && err_q;
   assign mipi_rst               = mipi_q;
   assign irq                    = irq_q;
   assign cam_trigger_capture    = trig_q;
   assign cam_continuous_capture = cont_q;
   assign cam_rgb_gray           = gray_q;
   assign cam_dma_init_done      = dinit_q;

endmodule

// File: tb/tb_apb3_cam_multi_ctrl.sv
// Directed table-driven bench for apb3_cam_multi_ctrl plus hand sequences for
// trigger pulse, interrupt, frame counter and mid-transfer reset behaviour.
module tb_apb3_cam_multi_ctrl;
   localparam int AW = 12;
   localparam int NC = 2;
   localparam int NV = 19;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [AW-1:0]   PADDR = '0;
   logic            PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0]     PWDATA = '0;
   logic [31:0]     PRDATA;
   logic            PREADY, PSLVERROR, mipi_rst, irq;
   logic [16*NC-1:0] cam_rgb_control;
   logic [NC-1:0]   cam_trigger_capture, cam_continuous_capture, cam_rgb_gray, cam_dma_init_done;
   logic [32*NC-1:0] cam_frames_per_second, cam_dma_fifo_rcount, cam_dma_fifo_wcount, cam_dma_status;
   logic [NC-1:0]   cam_frame_done = '0;
   logic [31:0]     debug_fifo_status, debug_display_dma_fifo_rcount, debug_display_dma_fifo_wcount;

   int checks = 0;
   int errors = 0;
   logic [NC-1:0] trig_mid, trig_rdy, trig_aft;

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl [NV];

   apb3_cam_multi_ctrl #(.ADDR_WIDTH(AW), .NUM_CAM(NC)) dut (
      .clk(clk), .resetn(resetn),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERROR(PSLVERROR),
      .mipi_rst(mipi_rst), .irq(irq),
      .cam_rgb_control(cam_rgb_control), .cam_trigger_capture(cam_trigger_capture),
      .cam_continuous_capture(cam_continuous_capture), .cam_rgb_gray(cam_rgb_gray),
      .cam_dma_init_done(cam_dma_init_done),
      .cam_frames_per_second(cam_frames_per_second), .cam_dma_fifo_rcount(cam_dma_fifo_rcount),
      .cam_dma_fifo_wcount(cam_dma_fifo_wcount), .cam_dma_status(cam_dma_status),
      .cam_frame_done(cam_frame_done),
      .debug_fifo_status(debug_fifo_status),
      .debug_display_dma_fifo_rcount(debug_display_dma_fifo_rcount),
      .debug_display_dma_fifo_wcount(debug_display_dma_fifo_wcount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One APB transfer; pmask pulses cam_frame_done during the ACCESS cycle.
   task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [NC-1:0] pmask, output logic [31:0] rd, output logic err);
      int cnt;
      @(posedge clk); #1;
      PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
         cam_frame_done = (cnt == 1) ? pmask : '0;
         if (cnt == 1) trig_mid = cam_trigger_capture;
      end while (!PREADY && cnt < 10);
      cam_frame_done = '0;
      rd = PRDATA;
      err = PSLVERROR;
      trig_rdy = cam_trigger_capture;
      chk($sformatf("latency_%03h", addr), 32'(cnt), 32'd2);
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      trig_aft = cam_trigger_capture;
   endtask

   task automatic pulse(input logic [NC-1:0] m);
      @(posedge clk); #1; cam_frame_done = m;
      @(posedge clk); #1; cam_frame_done = '0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      cam_frames_per_second = {32'h2222_0001, 32'h1111_0001};
      cam_dma_fifo_rcount   = {32'h2222_0002, 32'h1111_0002};
      cam_dma_fifo_wcount   = {32'h2222_0003, 32'h1111_0003};
      cam_dma_status        = {32'h2222_0004, 32'h1111_0004};
      debug_fifo_status             = 32'hDEAD_0001;
      debug_display_dma_fifo_rcount = 32'hDEAD_0002;
      debug_display_dma_fifo_wcount = 32'hDEAD_0003;

      tbl[0]  = '{1'b1, 12'h100, 32'h0000_1234, 32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b0, 12'h100, 32'h0,         32'h0000_1234, 1'b0};
      tbl[2]  = '{1'b0, 12'h004, 32'h0,         32'hABCD_5602, 1'b0};
      tbl[3]  = '{1'b0, 12'h1C0, 32'h0,         32'h0000_0000, 1'b1};
      tbl[4]  = '{1'b0, 12'h10C, 32'h0,         32'h1111_0001, 1'b0};
      tbl[5]  = '{1'b0, 12'h150, 32'h0,         32'h2222_0002, 1'b0};
      tbl[6]  = '{1'b0, 12'h014, 32'h0,         32'hDEAD_0003, 1'b0};
      tbl[7]  = '{1'b0, 12'h00C, 32'h0,         32'hDEAD_0001, 1'b0};
      tbl[8]  = '{1'b1, 12'h004, 32'h0000_FFFF, 32'hDEAD_0001, 1'b1};
      tbl[9]  = '{1'b0, 12'h018, 32'h0,         32'h0000_0000, 1'b1};
      tbl[10] = '{1'b1, 12'h148, 32'h0000_0003, 32'h0000_0000, 1'b0};
      tbl[11] = '{1'b0, 12'h14B, 32'h0,         32'h0000_0003, 1'b0};
      tbl[12] = '{1'b1, 12'h140, 32'hFFFF_ABCD, 32'h0000_0003, 1'b0};
      tbl[13] = '{1'b0, 12'h140, 32'h0,         32'h0000_ABCD, 1'b0};
      tbl[14] = '{1'b0, 12'h120, 32'h0,         32'h0000_0000, 1'b1};
      tbl[15] = '{1'b1, 12'h108, 32'h0000_0001, 32'h0000_0000, 1'b0};
      tbl[16] = '{1'b0, 12'h108, 32'h0,         32'h0000_0001, 1'b0};
      tbl[17] = '{1'b0, 12'h000, 32'h0,         32'h0000_0000, 1'b0};
      tbl[18] = '{1'b0, 12'h200, 32'h0,         32'h0000_0000, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready", 32'(PREADY), 32'd0);
      chk("rst_prdata", PRDATA, 32'd0);
      chk("rst_pslverr", 32'(PSLVERROR), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_mipi", 32'(mipi_rst), 32'd0);
      chk("rst_rgb", 32'(cam_rgb_control), 32'd0);
      resetn = 1'b1;

      // Table-driven register accesses
      for (int i = 0; i < NV; i++) begin
         apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, '0, rd, er);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      end
      chk("rgb_out", 32'(cam_rgb_control), 32'hABCD_1234);
      chk("gray_out", 32'(cam_rgb_gray), 32'd3);
      chk("dinit_out", 32'(cam_dma_init_done), 32'd2);

      // Self-clearing trigger with continuous capture
      apb(1'b1, 12'h144, 32'h3, '0, rd, er);
      chk("trig_before", 32'(trig_mid), 32'd0);
      chk("trig_pulse", 32'(trig_rdy), 32'd2);
      chk("trig_after", 32'(trig_aft), 32'd0);
      chk("cont_out", 32'(cam_continuous_capture), 32'd2);
      apb(1'b0, 12'h144, 32'h0, '0, rd, er);
      chk("cap_readback", rd, 32'h2);

      // Interrupt: enable cam0, set, W1C racing a new set, plain W1C
      apb(1'b1, 12'h000, 32'h100, '0, rd, er);
      chk("mipi_off", 32'(mipi_rst), 32'd0);
      @(posedge clk); #1; cam_frame_done = 2'b01;
      @(posedge clk); #1; cam_frame_done = 2'b00;
      chk("irq_lag", 32'(irq), 32'd0);
      @(posedge clk); #1;
      chk("irq_set", 32'(irq), 32'd1);
      apb(1'b0, 12'h008, 32'h0, '0, rd, er);
      chk("irqst_set", rd, 32'h1);
      apb(1'b1, 12'h008, 32'h1, 2'b01, rd, er);
      apb(1'b0, 12'h008, 32'h0, '0, rd, er);
      chk("irqst_set_wins", rd, 32'h1);
      apb(1'b1, 12'h008, 32'h1, '0, rd, er);
      apb(1'b0, 12'h008, 32'h0, '0, rd, er);
      chk("irqst_clr", rd, 32'h0);
      chk("irq_clr", 32'(irq), 32'd0);

      // Frame counters, masked interrupt, RO and out-of-range writes
      apb(1'b0, 12'h11C, 32'h0, '0, rd, er);
      chk("fcnt0_two", rd, 32'd2);
      for (int k = 0; k < 3; k++) pulse(2'b10);
      apb(1'b0, 12'h15C, 32'h0, '0, rd, er);
      chk("fcnt1_three", rd, 32'd3);
      apb(1'b0, 12'h008, 32'h0, '0, rd, er);
      chk("irqst_cam1", rd, 32'h2);
      chk("irq_masked", 32'(irq), 32'd0);
      apb(1'b1, 12'h10C, 32'h5, '0, rd, er);
      chk("ro_wr_err", 32'(er), 32'd1);
      apb(1'b1, 12'h14C, 32'h5, '0, rd, er);
      chk("ro_wr_err_cam1", 32'(er), 32'd1);
      apb(1'b1, 12'h1C0, 32'hFFFF, '0, rd, er);
      chk("cam3_wr_err", 32'(er), 32'd1);
      chk("rgb_unchanged", 32'(cam_rgb_control), 32'hABCD_1234);
      apb(1'b0, 12'h15C, 32'h0, '0, rd, er);
      chk("fcnt1_unchanged", rd, 32'd3);
      apb(1'b1, 12'h15C, 32'h99, '0, rd, er);
      chk("fcnt_wr_ok", 32'(er), 32'd0);
      apb(1'b0, 12'h15C, 32'h0, '0, rd, er);
      chk("fcnt1_cleared", rd, 32'd0);
      apb(1'b1, 12'h11C, 32'h55, 2'b01, rd, er);
      apb(1'b0, 12'h11C, 32'h0, '0, rd, er);
      chk("fcnt0_clr_inc", rd, 32'd1);

      // Reset in the ACCESS cycle of a CTRL write
      apb(1'b1, 12'h000, 32'h101, '0, rd, er);
      chk("mipi_on", 32'(mipi_rst), 32'd1);
      apb(1'b0, 12'h000, 32'h0, '0, rd, er);
      chk("ctrl_read", rd, 32'h101);
      @(posedge clk); #1;
      PADDR = 12'h000; PWRITE = 1'b1; PWDATA = 32'h1; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      chk("mid_rst_mipi", 32'(mipi_rst), 32'd0);
      chk("mid_rst_prdata", PRDATA, 32'd0);
      chk("mid_rst_pready", 32'(PREADY), 32'd0);
      chk("mid_rst_rgb", 32'(cam_rgb_control), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_pready%0d", k), 32'(PREADY), 32'd0);
      end
      chk("post_rst_mipi", 32'(mipi_rst), 32'd0);
      PSEL = 1'b0; PENABLE = 1'b0;
      apb(1'b0, 12'h000, 32'h0, '0, rd, er);
      chk("post_rst_ctrl", rd, 32'h0);
      apb(1'b0, 12'h144, 32'h0, '0, rd, er);
      chk("post_rst_cap", rd, 32'h0);
      apb(1'b0, 12'h008, 32'h0, '0, rd, er);
      chk("post_rst_irqst", rd, 32'h0);
      apb(1'b0, 12'h11C, 32'h0, '0, rd, er);
      chk("post_rst_fcnt0", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
